// File: rtl/game_pkg.sv
// Shared game-datapath definitions: scheduler state encoding, default timing
// constants and the 16-bit Galois LFSR step.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_SELECT = 2'd2,
    ST_ISSUE  = 2'd3
  } sched_state_e;

  localparam int CNT_W                = 28;
  localparam int DEF_INIT_INTERVAL    = 50_000_000;
  localparam int DEF_MIN_INTERVAL     = 10_000_000;
  localparam int DEF_INTERVAL_STEP    = 5_000_000;
  localparam int DEF_SPAWNS_PER_LEVEL = 8;
  localparam int DEF_MAX_LEVEL        = 7;

  // x^16+x^14+x^13+x^11+1 in right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with seed, enable and synchronous reset; exposes only
// the low OUT_W bits of its state.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [OUT_W-1:0] rnd_o
);

  logic [15:0] state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)     state_q <= SEED;
    else if (en_i) state_q <= lfsr_next(state_q);
  end

  assign rnd_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/spawn_scheduler.sv
// Spawn sequencer: counts down the spawn interval, picks a free slot
// round-robin plus a pseudo-random lane, and hands it over via valid/ready.
module spawn_scheduler
  import game_pkg::*;
#(
  parameter int          N_SLOTS          = 4,
  parameter int          N_LANES          = 8,
  parameter int          INIT_INTERVAL    = DEF_INIT_INTERVAL,
  parameter int          MIN_INTERVAL     = DEF_MIN_INTERVAL,
  parameter int          INTERVAL_STEP    = DEF_INTERVAL_STEP,
  parameter int          SPAWNS_PER_LEVEL = DEF_SPAWNS_PER_LEVEL,
  parameter int          MAX_LEVEL        = DEF_MAX_LEVEL,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1,
  localparam int         SLOT_W           = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
  localparam int         LANE_W           = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic               clk,
  input  logic               hard_reset,
  input  logic               game_en,
  input  logic               game_reset,
  input  logic               freeze,
  input  logic [N_SLOTS-1:0] slot_busy,
  input  logic               spawn_ready,
  output logic               spawn_valid,
  output logic [SLOT_W-1:0]  spawn_slot,
  output logic [LANE_W-1:0]  spawn_lane,
  output logic [2:0]         level
);

  localparam int SPC_W = $clog2(SPAWNS_PER_LEVEL + 1);

  sched_state_e           state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, interval_q, interval_d, interval_dec;
  logic [2:0]             level_q, level_d;
  logic [SPC_W-1:0]       spawn_cnt_q, spawn_cnt_d;
  logic [SLOT_W-1:0]      rr_q, rr_d, slot_q, slot_d, pick;
  logic [LANE_W-1:0]      lane_q, lane_d, rnd;
  logic                   valid_q, valid_d, found;
  logic [SLOT_W:0]        scan;

  lfsr16 #(.SEED(LFSR_SEED), .OUT_W(LANE_W)) u_lfsr (
    .clk_i (clk),
    .rst_i (hard_reset),
    .en_i  (1'b1),
    .rnd_o (rnd)
  );

  // First free slot at or after rr_q, wrapping around N_SLOTS.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      scan = {1'b0, rr_q} + (SLOT_W+1)'(i);
      if (scan >= (SLOT_W+1)'(N_SLOTS)) scan = scan - (SLOT_W+1)'(N_SLOTS);
      if (!found && !slot_busy[scan[SLOT_W-1:0]]) begin
        found = 1'b1;
        pick  = scan[SLOT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hard_reset || game_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_W'(INIT_INTERVAL);
      interval_q  <= CNT_W'(INIT_INTERVAL);
      level_q     <= '0;
      spawn_cnt_q <= '0;
      rr_q        <= '0;
      valid_q     <= 1'b0;
      slot_q      <= '0;
      lane_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      interval_q  <= interval_d;
      level_q     <= level_d;
      spawn_cnt_q <= spawn_cnt_d;
      rr_q        <= rr_d;
      valid_q     <= valid_d;
      slot_q      <= slot_d;
      lane_q      <= lane_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (game_en) state_d = ST_COUNT;
      ST_COUNT:  if (!game_en) state_d = ST_IDLE;
                 else if (!freeze && cnt_q == '0) state_d = ST_SELECT;
      ST_SELECT: if (!game_en) state_d = ST_IDLE;
                 else if (found) state_d = ST_ISSUE;
      ST_ISSUE:  if (spawn_ready) state_d = ST_COUNT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Clamp test precedes the subtraction so the interval can never wrap.
  assign interval_dec = (interval_q >= CNT_W'(MIN_INTERVAL + INTERVAL_STEP))
                      ? interval_q - CNT_W'(INTERVAL_STEP) : CNT_W'(MIN_INTERVAL);

  always_comb begin
    cnt_d       = cnt_q;
    interval_d  = interval_q;
    level_d     = level_q;
    spawn_cnt_d = spawn_cnt_q;
    rr_d        = rr_q;
    valid_d     = valid_q;
    slot_d      = slot_q;
    lane_d      = lane_q;
    case (state_q)
      ST_COUNT:
        if (game_en && !freeze && cnt_q != '0) cnt_d = cnt_q - 1'b1;
      ST_SELECT:
        if (game_en && found) begin
          slot_d  = pick;
          lane_d  = rnd;
          valid_d = 1'b1;
        end
      ST_ISSUE:
        if (spawn_ready) begin
          valid_d = 1'b0;
          rr_d    = (slot_q == SLOT_W'(N_SLOTS - 1)) ? '0 : slot_q + 1'b1;
          if (spawn_cnt_q == SPC_W'(SPAWNS_PER_LEVEL - 1)) begin
            spawn_cnt_d = '0;
            level_d     = (level_q == 3'(MAX_LEVEL)) ? level_q : level_q + 1'b1;
            interval_d  = interval_dec;
            cnt_d       = interval_dec;
          end else begin
            spawn_cnt_d = spawn_cnt_q + 1'b1;
            cnt_d       = interval_q;
          end
        end
      default: ;
    endcase
  end

  assign spawn_valid = valid_q;
  assign spawn_slot  = slot_q;
  assign spawn_lane  = lane_q;
  assign level       = level_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed + randomized bench for spawn_scheduler against a behavioural model
// of spawn timing, slot choice, lane sequence and difficulty level.
module tb_spawn_scheduler;

  localparam int NS = 4, INIT = 10, MINI = 4, STEP = 3, SPL = 2, MAXL = 7;

  logic          clk = 1'b0;
  logic          hard_reset, game_en, game_reset, freeze, spawn_ready;
  logic [NS-1:0] slot_busy;
  logic          spawn_valid;
  logic [1:0]    spawn_slot;
  logic [2:0]    spawn_lane, level;

  always #5 clk = ~clk;

  spawn_scheduler #(
    .N_SLOTS(NS), .N_LANES(8), .INIT_INTERVAL(INIT), .MIN_INTERVAL(MINI),
    .INTERVAL_STEP(STEP), .SPAWNS_PER_LEVEL(SPL), .MAX_LEVEL(MAXL)
  ) dut (
    .clk(clk), .hard_reset(hard_reset), .game_en(game_en), .game_reset(game_reset),
    .freeze(freeze), .slot_busy(slot_busy), .spawn_ready(spawn_ready),
    .spawn_valid(spawn_valid), .spawn_slot(spawn_slot), .spawn_lane(spawn_lane),
    .level(level)
  );

  // Reference lane source: the polynomial's sequence, frozen only by hard_reset.
  logic [15:0] m_lfsr, m_prev;
  function automatic logic [15:0] poly_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    m_lfsr <= hard_reset ? 16'hACE1 : poly_step(m_lfsr);
  end

  int total = 0, bad = 0, cyc = 0, exp_rise = 0, spawns = 0, rr_m = 0;
  int a_slot = 0;
  logic [2:0] a_lane;

  function automatic int m_interval(input int n_sp);
    int v;
    v = INIT - STEP * (n_sp / SPL);
    return (v < MINI) ? MINI : v;
  endfunction
  function automatic int m_level(input int n_sp);
    return (n_sp / SPL > MAXL) ? MAXL : n_sp / SPL;
  endfunction
  function automatic int m_slot(input int rr, input logic [NS-1:0] busy);
    for (int i = 0; i < NS; i++)
      if (!busy[(rr + i) % NS]) return (rr + i) % NS;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for spawn_valid and checks its arrival cycle, slot and lane.
  task automatic await_rise(input string tag);
    int n = 0;
    while (!spawn_valid && n < 300) begin tick(); n++; end
    a_slot = m_slot(rr_m, slot_busy);
    a_lane = m_prev[2:0];
    check({tag, "_rise_cycle"}, cyc, exp_rise);
    check({tag, "_slot"}, spawn_slot, a_slot);
    check({tag, "_lane"}, spawn_lane, a_lane);
  endtask

  // Holds ready low for 'hold' cycles (request must stay put), then accepts.
  task automatic accept(input int hold, input string tag);
    if (hold > 0) begin
      spawn_ready = 1'b0;
      repeat (hold) begin
        tick();
        check({tag, "_stable"}, {spawn_valid, spawn_slot, spawn_lane}, {1'b1, 2'(a_slot), a_lane});
      end
    end
    spawn_ready = 1'b1;
    tick();
    spawns++;
    rr_m = (a_slot + 1) % NS;
    check({tag, "_valid_drop"}, spawn_valid, 0);
    check({tag, "_level"}, level, m_level(spawns));
    exp_rise = cyc + m_interval(spawns) + 2;
  endtask

  initial begin
    int seen;
    logic [NS-1:0] b;
    hard_reset = 1'b1; game_en = 1'b0; game_reset = 1'b0; freeze = 1'b0;
    slot_busy = '0; spawn_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", spawn_valid, 0);
    check("rst_slot", spawn_slot, 0);
    check("rst_lane", spawn_lane, 0);
    check("rst_level", level, 0);
    hard_reset = 1'b0;
    repeat (3) tick();
    check("idle_no_spawn", spawn_valid, 0);

    // First spawn: the edge sampling game_en is edge 1, valid is up after edge 13.
    game_en = 1'b1;
    exp_rise = cyc + 1 + INIT + 2;
    await_rise("s1");
    accept(0, "s1");

    // Difficulty ramp over the next spawns.
    for (int k = 2; k <= 7; k++) begin
      await_rise($sformatf("s2_%0d", k));
      accept(0, $sformatf("s2_%0d", k));
    end

    // All slots busy: no request until one frees up.
    slot_busy = 4'hF;
    seen = 0;
    repeat (m_interval(spawns) + 10) begin tick(); if (spawn_valid) seen++; end
    check("s3_blocked", seen, 0);
    slot_busy = 4'b1011;
    exp_rise = cyc + 1;
    await_rise("s3_free2");
    accept(0, "s3_free2");
    slot_busy = '0;
    await_rise("s3_next");

    // Backpressure with game_en dropped mid-request.
    game_en = 1'b0;
    accept(5, "s4");
    seen = 0;
    repeat (20) begin tick(); if (spawn_valid) seen++; end
    check("s4_idle", seen, 0);
    game_en = 1'b1;
    exp_rise = cyc + 1 + m_interval(spawns) + 2;
    await_rise("s4_resume");
    accept(0, "s4_resume");

    // Freeze mid-count delays the spawn one-for-one.
    repeat (2) tick();
    freeze = 1'b1;
    repeat (20) tick();
    freeze = 1'b0;
    exp_rise += 20;
    await_rise("s5");
    accept(0, "s5");

    // game_reset collides with the handshake: reset wins.
    await_rise("s6_pre");
    game_reset = 1'b1; spawn_ready = 1'b1;
    tick();
    game_reset = 1'b0;
    check("s6_valid", spawn_valid, 0);
    check("s6_level", level, 0);
    spawns = 0; rr_m = 0;
    exp_rise = cyc + 1 + INIT + 2;
    await_rise("s6_a");
    accept(0, "s6_a");
    await_rise("s6_b");
    accept(0, "s6_b");

    // Random occupancy and ready latency.
    for (int k = 0; k < 16; k++) begin
      await_rise($sformatf("rnd%0d", k));
      accept($urandom_range(0, 3), $sformatf("rnd%0d", k));
      b = NS'($urandom_range(0, 15));
      if (&b) b[$urandom_range(0, NS - 1)] = 1'b0;
      slot_busy = b;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spawn_scheduler.md
Name: spawn_scheduler

Overview:
- Sequences object spawning (eggs/enemies) for the game datapath.
- Runs only while the game controller enables play, pauses during the hit/freeze window, and restarts on each game_reset pulse.
- Picks a free object slot round-robin and a pseudo-random lane, then hands the spawn to the object datapath via a valid/ready handshake.
- Raises difficulty by shortening the spawn interval as spawns accumulate.

Parameters:
N_SLOTS, 4, number of object slots in the datapath (SLOT_W = clog2(N_SLOTS))
N_LANES, 8, number of horizontal lanes; must be a power of two (LANE_W = clog2(N_LANES))
INIT_INTERVAL, 50000000, spawn interval at level 0, in clk cycles (28-bit)
MIN_INTERVAL, 10000000, lower clamp for the interval
INTERVAL_STEP, 5000000, interval reduction per level-up
SPAWNS_PER_LEVEL, 8, accepted spawns per level-up
MAX_LEVEL, 7, level saturation value
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
clk  in  1  system clock
hard_reset  in  1  synchronous, active-high reset
game_en  in  1  play enabled, from the game controller
game_reset  in  1  one-cycle restart pulse, from the game controller
freeze  in  1  high while the player is in the hit state; pauses the interval count
slot_busy  in  N_SLOTS  bit i high = slot i holds a live object
spawn_ready  in  1  datapath accepts the spawn
spawn_valid  out  1  spawn request
spawn_slot  out  SLOT_W  target slot
spawn_lane  out  LANE_W  target lane
level  out  3  current difficulty level

Behaviour:
- One clock domain. Reset is synchronous and active-high on hard_reset. All outputs are registered.
- Priority: hard_reset > game_reset > normal operation.
- Reset values: state IDLE, cnt=INIT_INTERVAL, interval=INIT_INTERVAL, level=0, spawn_cnt=0, rr_ptr=0, lfsr=LFSR_SEED, spawn_valid=0, spawn_slot=0, spawn_lane=0.
- game_reset: same as reset, except the LFSR keeps running so lane sequences are not repeated between games.
- The LFSR advances every clock outside hard_reset, in every state.
- States:
  - IDLE: when game_en=1, go to COUNT; cnt already equals interval.
  - COUNT:
    - game_en=0: go to IDLE; cnt held.
    - else freeze=1: hold everything.
    - else cnt==0: go to SELECT.
    - else cnt decrements by 1.
  - SELECT:
    - Scan slot_busy from rr_ptr upward, wrapping; take the first 0.
    - If a free slot is found: latch spawn_slot, latch spawn_lane = lfsr[LANE_W-1:0], assert spawn_valid next cycle, go to ISSUE.
    - If no slot is free: stay in SELECT and rescan every cycle.
    - game_en=0 in SELECT: go to IDLE.
  - ISSUE:
    - spawn_valid=1; spawn_slot and spawn_lane are stable until spawn_ready=1.
    - game_en and freeze do not withdraw the request; only hard_reset or game_reset do.
    - On spawn_ready=1:
      - spawn_valid drops.
      - rr_ptr = spawn_slot+1, wrapping to 0.
      - spawn_cnt increments. When it reaches SPAWNS_PER_LEVEL, it becomes 0, level = min(level+1, MAX_LEVEL), and interval = max(interval-INTERVAL_STEP, MIN_INTERVAL). The subtraction must not underflow: compare before subtracting.
      - cnt loads the updated interval; go to COUNT.
- Timing: with ready=1, slots free and no freeze, spawn_valid rises 13 cycles after game_en is first sampled high when interval=10. The steady-state spawn period is interval+3 cycles.
- Interval keeps shrinking at MAX_LEVEL (level saturates, interval does not).
- game_reset and spawn_ready in the same cycle: reset wins; the spawn is not counted.

Decomposition:
- Shared package game_pkg holds:
  - state encodings (IDLE/COUNT/SELECT/ISSUE)
  - default timing constants
  - the LFSR polynomial x^16+x^14+x^13+x^11+1
- One sub-module, lfsr16: Galois LFSR with seed parameter, enable, synchronous reset.

Test Plan:
All scenarios override INIT_INTERVAL=10, MIN_INTERVAL=4, INTERVAL_STEP=3, SPAWNS_PER_LEVEL=2, N_SLOTS=4.
1. hard_reset, then game_en=1, slot_busy=0, spawn_ready=1 -> first spawn_valid 13 cycles after game_en sampled; slots 0,1,... in order; period 13; lane matches the lfsr16 model.
2. Run 6 spawns -> level 1 after spawn 2 (period 10); level 2 after spawn 4 (period 7); level 3 after spawn 6 (interval clamped at 4, period 7).
3. slot_busy=4'b1111 at SELECT -> no spawn_valid; clear bit 2 -> spawn_valid next cycle with spawn_slot=2; next selection starts at slot 3.
4. spawn_ready=0 for 5 cycles during ISSUE, with game_en dropped meanwhile -> spawn_valid, slot and lane stable; accepted on ready; then IDLE.
5. freeze=1 for 20 cycles mid-COUNT -> spawn delayed by exactly 20 cycles; level unchanged.
6. game_reset pulse coincident with spawn_ready in ISSUE -> spawn_valid=0 next cycle; level=0; spawn_cnt=0; state IDLE; next spawn 13 cycles after game_en is sampled.
